// File: rtl/asrv32_bus_pkg.sv
// Shared definitions for the asrv32 data-bus decoder: FSM states, index-width helper
// and the default RAM/CLINT address windows.
package asrv32_bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK   = 32'h8000_0000;
    localparam logic [31:0] CLINT_BASE = 32'h8000_0000;
    localparam logic [31:0] CLINT_MASK = 32'hFFFF_FF80;

    // A single-device bus still needs a 1-bit select index.
    function automatic int dev_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/asrv32_bus_arbiter_n_if.sv
// Core-side data port of the asrv32 bus decoder: request fields plus the
// registered response (rdata/ack/err).
interface asrv32_bus_arbiter_n_if;
    logic [31:0] i_data_addr;
    logic [31:0] i_wdata;
    logic        i_wr_en;
    logic [3:0]  i_wr_mask;
    logic        i_stb_data;
    logic [31:0] o_rdata;
    logic        o_ack_data;
    logic        o_err;

    modport master (
        output i_data_addr, i_wdata, i_wr_en, i_wr_mask, i_stb_data,
        input  o_rdata, o_ack_data, o_err
    );

    modport slave (
        input  i_data_addr, i_wdata, i_wr_en, i_wr_mask, i_stb_data,
        output o_rdata, o_ack_data, o_err
    );
endinterface

// File: rtl/asrv32_addr_decoder.sv
// Combinational base/mask address decoder; the lowest matching device index wins.
module asrv32_addr_decoder #(
    parameter int                         NUM_DEVICES = 4,
    parameter int                         IDX_W       = 2,
    parameter logic [32*NUM_DEVICES-1:0]  DEV_BASE    = '0,
    parameter logic [32*NUM_DEVICES-1:0]  DEV_MASK    = '0
) (
    input  logic [31:0]      i_addr,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_sel
);

    // Scan from the highest index down so the lowest hit is written last.
    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        for (int k = NUM_DEVICES - 1; k >= 0; k--) begin
            if ((i_addr & DEV_MASK[32*k +: 32]) == DEV_BASE[32*k +: 32]) begin
                o_hit = 1'b1;
                o_sel = IDX_W'(k);
            end else begin
                o_hit = o_hit;
            end
        end
    end

endmodule

// File: rtl/asrv32_bus_arbiter_n.sv
// Registered data-bus decoder between the asrv32 core and NUM_DEVICES slaves.
// Define ASRV32_BUS_TIMEOUT_EN to release the bus with an error when a slave never acks.
module asrv32_bus_arbiter_n
    import asrv32_bus_pkg::*;
#(
    parameter int                         NUM_DEVICES    = 4,
    parameter logic [32*NUM_DEVICES-1:0]  DEV_BASE       = {32'h8000_0200, 32'h8000_0100, CLINT_BASE, RAM_BASE},
    parameter logic [32*NUM_DEVICES-1:0]  DEV_MASK       = {32'hFFFF_FF00, 32'hFFFF_FF00, CLINT_MASK, RAM_MASK},
    parameter int                         TIMEOUT_CYCLES = 255
) (
    input  logic                       i_clk,
    input  logic                       rst_n,
    asrv32_bus_arbiter_n_if.slave      bus,
    output logic [32*NUM_DEVICES-1:0]  o_dev_data_addr,
    output logic [32*NUM_DEVICES-1:0]  o_dev_wdata,
    output logic [4*NUM_DEVICES-1:0]   o_dev_wr_mask,
    output logic [NUM_DEVICES-1:0]     o_dev_wr_en,
    output logic [NUM_DEVICES-1:0]     o_dev_stb_data,
    input  logic [32*NUM_DEVICES-1:0]  i_dev_rdata,
    input  logic [NUM_DEVICES-1:0]     i_dev_ack_data
);

    localparam int IDX_W = dev_idx_w(NUM_DEVICES);

    logic                   w_hit;
    logic [IDX_W-1:0]       w_sel;
    logic [NUM_DEVICES-1:0] w_sel_onehot;
    logic [31:0]            w_dev_rdata;
    logic                   w_dev_ack;

    bus_state_e             r_state;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [3:0]             r_mask;
    logic                   r_wr;
    logic [IDX_W-1:0]       r_sel;
    logic [NUM_DEVICES-1:0] r_dev_stb;
    logic [NUM_DEVICES-1:0] r_dev_wr;
    logic [31:0]            r_rdata;
    logic                   r_ack;
    logic                   r_err;

`ifdef ASRV32_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]       r_cnt;
`else
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
    end
`endif

    asrv32_addr_decoder #(
        .NUM_DEVICES (NUM_DEVICES),
        .IDX_W       (IDX_W),
        .DEV_BASE    (DEV_BASE),
        .DEV_MASK    (DEV_MASK)
    ) u_dec (
        .i_addr (bus.i_data_addr),
        .o_hit  (w_hit),
        .o_sel  (w_sel)
    );

    // One-hot of the decoded device and the response lines of the latched device.
    always_comb begin
        w_sel_onehot = '0;
        for (int k = 0; k < NUM_DEVICES; k++) begin
            w_sel_onehot[k] = (w_sel == IDX_W'(k));
        end
        w_dev_rdata = i_dev_rdata[32*int'(r_sel) +: 32];
        w_dev_ack   = i_dev_ack_data[r_sel];
    end

    // Request/response FSM; strobes and ack/err are one-cycle pulses by default.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= 32'h0000_0000;
            r_wdata   <= 32'h0000_0000;
            r_mask    <= 4'h0;
            r_wr      <= 1'b0;
            r_sel     <= '0;
            r_dev_stb <= '0;
            r_dev_wr  <= '0;
            r_rdata   <= 32'h0000_0000;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
`ifdef ASRV32_BUS_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_dev_stb <= '0;
            r_dev_wr  <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_stb_data && w_hit) begin
                        r_addr    <= bus.i_data_addr;
                        r_wdata   <= bus.i_wdata;
                        r_mask    <= bus.i_wr_mask;
                        r_wr      <= bus.i_wr_en;
                        r_sel     <= w_sel;
                        r_dev_stb <= w_sel_onehot;
                        r_dev_wr  <= bus.i_wr_en ? w_sel_onehot : '0;
                        r_state   <= ST_BUSY;
`ifdef ASRV32_BUS_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end else if (bus.i_stb_data) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0000_0000;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (w_dev_ack) begin
                        r_ack   <= 1'b1;
                        r_rdata <= r_wr ? 32'h0000_0000 : w_dev_rdata;
                        r_state <= ST_IDLE;
`ifdef ASRV32_BUS_TIMEOUT_EN
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0000_0000;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
`else
                    end else begin
                        r_state <= ST_BUSY;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_rdata     = r_rdata;
    assign bus.o_ack_data  = r_ack;
    assign bus.o_err       = r_err;
    assign o_dev_data_addr = {NUM_DEVICES{r_addr}};
    assign o_dev_wdata     = {NUM_DEVICES{r_wdata}};
    assign o_dev_wr_mask   = {NUM_DEVICES{r_mask}};
    assign o_dev_wr_en     = r_dev_wr;
    assign o_dev_stb_data  = r_dev_stb;

endmodule
